// File: rtl/encode_sched_if.sv
// Encode scheduler bus: uncoded FIFO read port, encoder launch/result
// handshake, UART transmitter handshake and status outputs.
interface encode_sched_if #(
  parameter int DW = 128
);
  logic          en;
  logic          fifo_empty;
  logic          fifo_rinc;
  logic [DW-1:0] fifo_rdata;
  logic          enc_ready;
  logic          enc_vld_i;
  logic [DW-1:0] enc_din;
  logic          enc_vld_o;
  logic [2*DW-1:0] enc_dout;
  logic          tx_flag;
  logic [2*DW-1:0] tx_data;
  logic          tx_ok;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          err_tmo;
  logic          err_ovr;

  // Scheduler side.
  modport master (
    input  en, fifo_empty, fifo_rdata, enc_ready, enc_vld_o, enc_dout, tx_ok,
    output fifo_rinc, enc_vld_i, enc_din, tx_flag, tx_data, busy,
           frame_cnt, err_tmo, err_ovr
  );

  // FIFO / encoder / transmitter / control side.
  modport slave (
    output en, fifo_empty, fifo_rdata, enc_ready, enc_vld_o, enc_dout, tx_ok,
    input  fifo_rinc, enc_vld_i, enc_din, tx_flag, tx_data, busy,
           frame_cnt, err_tmo, err_ovr
  );
endinterface

// File: rtl/encode_sched.sv
// Encode scheduler: pops one word from the uncoded FIFO, launches it into
// the encoder, waits (bounded) for the coded frame, hands it to the UART
// transmitter and waits for completion. Exactly one frame in flight.
module encode_sched #(
  parameter int DW  = 128,
  parameter int TMO = 1024
) (
  input logic            clk,
  input logic            rst_n,
  encode_sched_if.master bus
);

  localparam int            CW       = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LAUNCH,
    S_WAIT_ENC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_tmo_cnt;
  logic [2*DW-1:0] r_tx_data;
  logic [15:0]     r_frame_cnt;
  logic            r_err_tmo;
  logic            r_err_ovr;
  logic            w_fifo_rinc;
  logic            w_enc_vld_i;
  logic            w_tx_flag;
  logic            w_enc_hit;
  logic            w_tmo_hit;

  // A result in WAIT_ENC always beats the timeout in the same cycle.
  assign w_enc_hit = (r_state == S_WAIT_ENC) && bus.enc_vld_o;
  assign w_tmo_hit = (r_state == S_WAIT_ENC) && !bus.enc_vld_o &&
                     (r_tmo_cnt == TMO_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and one-cycle strobe decode.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    w_fifo_rinc = 1'b0;
    w_enc_vld_i = 1'b0;
    w_tx_flag   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en && !bus.fifo_empty && bus.enc_ready) w_next = S_POP;
      end
      S_POP: begin
        w_fifo_rinc = 1'b1;
        w_next      = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_enc_vld_i = 1'b1;
        w_next      = S_WAIT_ENC;
      end
      S_WAIT_ENC: begin
        if (w_enc_hit)      w_next = S_SEND;
        else if (w_tmo_hit) w_next = S_IDLE;
      end
      S_SEND: begin
        w_tx_flag = 1'b1;
        w_next    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (bus.tx_ok) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Encoder timeout counter: cleared on launch, counts while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_tmo_cnt <= '0;
    else if (r_state == S_LAUNCH)                r_tmo_cnt <= '0;
    else if ((r_state == S_WAIT_ENC) && !w_enc_hit && !w_tmo_hit)
                                                 r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Coded frame holding register; only a WAIT_ENC result may load it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_tx_data <= '0;
    else if (w_enc_hit) r_tx_data <= bus.enc_dout;
  end

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_frame_cnt <= '0;
    else if ((r_state == S_WAIT_TX) && bus.tx_ok) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_tmo <= 1'b0;
      r_err_ovr <= 1'b0;
    end else begin
      if (w_tmo_hit) r_err_tmo <= 1'b1;
      if (bus.enc_vld_o && (r_state != S_WAIT_ENC)) r_err_ovr <= 1'b1;
    end
  end

  assign bus.fifo_rinc = w_fifo_rinc;
  assign bus.enc_vld_i = w_enc_vld_i;
  assign bus.enc_din   = bus.fifo_rdata;
  assign bus.tx_flag   = w_tx_flag;
  assign bus.tx_data   = r_tx_data;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.err_tmo   = r_err_tmo;
  assign bus.err_ovr   = r_err_ovr;

endmodule

// File: tb/tb_encode_sched.sv
// Directed bench for encode_sched (DW=128, TMO=16): single frame,
// back-to-back, timeout, overrun, flow control, mid-frame reset, wrap.
module tb_encode_sched;

  localparam int DW  = 128;
  localparam int TMO = 16;

  logic clk;
  logic rst_n;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int n_rinc  = 0;
  int n_launch = 0;
  int n_txf   = 0;

  logic [15:0] exp_frames;

  encode_sched_if #(.DW(DW)) bus ();

  encode_sched #(.DW(DW), .TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.fifo_rinc === 1'b1) n_rinc++;
    if (bus.enc_vld_i === 1'b1) n_launch++;
    if (bus.tx_flag === 1'b1)   n_txf++;
  end

  // Run-away guard.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From an IDLE cycle: qualify, check POP and LAUNCH, end in first WAIT_ENC cycle.
  task automatic start_frame(input logic [DW-1:0] word);
    bus.en         = 1'b1;
    bus.enc_ready  = 1'b1;
    bus.fifo_empty = 1'b0;
    tick();
    check("pop_rinc", bus.fifo_rinc, 1'b1);
    check("pop_busy", bus.busy, 1'b1);
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = word;
    tick();
    check("launch_vld", bus.enc_vld_i, 1'b1);
    check("launch_din", bus.enc_din, word);
    check("launch_rinc_low", bus.fifo_rinc, 1'b0);
    tick();
    check("wait_vld_low", bus.enc_vld_i, 1'b0);
  endtask

  // From first WAIT_ENC cycle: encoder answers enc_lat cycles after launch,
  // tx_ok tx_lat cycles after tx_flag; optional spurious result in WAIT_TX.
  task automatic finish_frame(input logic [2*DW-1:0] res, input int enc_lat,
                              input int tx_lat, input bit ovr);
    repeat (enc_lat - 1) tick();
    check("wait_no_txf", bus.tx_flag, 1'b0);
    bus.enc_vld_o = 1'b1;
    bus.enc_dout  = res;
    tick();
    bus.enc_vld_o = 1'b0;
    check("send_flag", bus.tx_flag, 1'b1);
    check("send_data", bus.tx_data, res);
    tick();
    check("waittx_flag_low", bus.tx_flag, 1'b0);
    if (ovr) begin
      bus.enc_vld_o = 1'b1;
      bus.enc_dout  = ~res;
      tick();
      bus.enc_vld_o = 1'b0;
      check("ovr_flag", bus.err_ovr, 1'b1);
      check("ovr_data_kept", bus.tx_data, res);
      check("ovr_busy", bus.busy, 1'b1);
      repeat (tx_lat - 2) tick();
    end else begin
      repeat (tx_lat - 1) tick();
    end
    check("waittx_busy", bus.busy, 1'b1);
    bus.tx_ok = 1'b1;
    tick();
    bus.tx_ok = 1'b0;
    exp_frames = exp_frames + 16'd1;
    check("done_busy", bus.busy, 1'b0);
    check("done_cnt", bus.frame_cnt, exp_frames);
  endtask

  initial begin
    int b_r, b_l, b_t;

    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    bus.enc_ready  = 1'b0;
    bus.enc_vld_o  = 1'b0;
    bus.enc_dout   = '0;
    bus.tx_ok      = 1'b0;
    exp_frames     = 16'd0;
    #2;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rinc", bus.fifo_rinc, 1'b0);
    check("rst_launch", bus.enc_vld_i, 1'b0);
    check("rst_txf", bus.tx_flag, 1'b0);
    check("rst_cnt", bus.frame_cnt, 16'd0);
    check("rst_tmo", bus.err_tmo, 1'b0);
    check("rst_ovr", bus.err_ovr, 1'b0);
    check("rst_txdata", bus.tx_data, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single frame.
    b_r = n_rinc; b_l = n_launch; b_t = n_txf;
    start_frame(128'h0123456789ABCDEF0123456789ABCDEF);
    finish_frame({128'h0123456789ABCDEF0123456789ABCDEF, 128'hFEDCBA9876543210FEDCBA9876543210}, 5, 20, 1'b0);
    check("single_rinc_n", n_rinc - b_r, 1);
    check("single_launch_n", n_launch - b_l, 1);
    check("single_txf_n", n_txf - b_t, 1);
    check("single_no_err", {bus.err_tmo, bus.err_ovr}, 2'b00);

    // Back-to-back: IDLE lasts exactly one cycle between frames.
    b_r = n_rinc; b_l = n_launch; b_t = n_txf;
    start_frame(128'h1111_0000_1111_0000_1111_0000_1111_0001);
    finish_frame(256'hA1, 3, 4, 1'b0);
    start_frame(128'h2222_0000_2222_0000_2222_0000_2222_0002);
    finish_frame(256'hB2, 1, 1, 1'b0);
    start_frame(128'h3333_0000_3333_0000_3333_0000_3333_0003);
    finish_frame(256'hC3, 7, 2, 1'b0);
    check("b2b_rinc_n", n_rinc - b_r, 3);
    check("b2b_launch_n", n_launch - b_l, 3);
    check("b2b_txf_n", n_txf - b_t, 3);
    check("b2b_cnt", bus.frame_cnt, 16'd4);

    // Encoder timeout: silent encoder, abort 16 cycles after launch.
    b_t = n_txf;
    start_frame(128'hDEAD);
    repeat (TMO - 1) tick();
    check("tmo_not_yet", bus.err_tmo, 1'b0);
    check("tmo_still_busy", bus.busy, 1'b1);
    tick();
    check("tmo_flag", bus.err_tmo, 1'b1);
    check("tmo_idle", bus.busy, 1'b0);
    check("tmo_cnt_same", bus.frame_cnt, exp_frames);
    check("tmo_no_txf", n_txf - b_t, 0);
    start_frame(128'hBEEF);
    finish_frame(256'hBEEF_0001, TMO, 3, 1'b0);
    check("tmo_sticky", bus.err_tmo, 1'b1);

    // Overrun: spurious encoder result during WAIT_TX.
    start_frame(128'h55AA);
    finish_frame(256'h55AA_55AA, 2, 6, 1'b1);
    check("ovr_sticky", bus.err_ovr, 1'b1);

    // Flow control: no qualification for 50 cycles in each case.
    b_r = n_rinc;
    bus.en = 1'b1; bus.enc_ready = 1'b1; bus.fifo_empty = 1'b1;
    repeat (50) tick();
    check("fc_empty_busy", bus.busy, 1'b0);
    bus.fifo_empty = 1'b0; bus.enc_ready = 1'b0;
    repeat (50) tick();
    check("fc_notready_busy", bus.busy, 1'b0);
    bus.enc_ready = 1'b1; bus.en = 1'b0;
    repeat (25) tick();
    bus.tx_ok = 1'b1;
    tick();
    bus.tx_ok = 1'b0;
    repeat (24) tick();
    check("fc_en_busy", bus.busy, 1'b0);
    check("fc_rinc_n", n_rinc - b_r, 0);
    check("fc_txok_ignored", bus.frame_cnt, exp_frames);

    // en dropped in WAIT_ENC: frame completes, then IDLE holds.
    start_frame(128'h7777);
    bus.en = 1'b0;
    finish_frame(256'h7777_8888, 4, 5, 1'b0);
    b_r = n_rinc;
    bus.fifo_empty = 1'b0;
    repeat (10) tick();
    check("endrop_hold_busy", bus.busy, 1'b0);
    check("endrop_hold_rinc", n_rinc - b_r, 0);

    // Reset in WAIT_TX drops the frame; nothing emitted afterwards.
    start_frame(128'h9999);
    repeat (2) tick();
    bus.enc_vld_o = 1'b1; bus.enc_dout = 256'h9999_0000;
    tick();
    bus.enc_vld_o = 1'b0;
    tick();
    check("pre_rst_busy", bus.busy, 1'b1);
    bus.fifo_empty = 1'b1;
    rst_n = 1'b0;
    #1;
    exp_frames = 16'd0;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_txdata", bus.tx_data, 256'd0);
    check("mid_rst_cnt", bus.frame_cnt, 16'd0);
    check("mid_rst_errs", {bus.err_tmo, bus.err_ovr}, 2'b00);
    check("mid_rst_txf", bus.tx_flag, 1'b0);
    b_r = n_rinc; b_l = n_launch; b_t = n_txf;
    @(negedge clk);
    rst_n = 1'b1;
    bus.en = 1'b1;
    tick();
    bus.tx_ok = 1'b1;
    tick();
    bus.tx_ok = 1'b0;
    repeat (5) tick();
    check("post_rst_strobes", (n_rinc - b_r) + (n_launch - b_l) + (n_txf - b_t), 0);
    check("post_rst_cnt", bus.frame_cnt, 16'd0);

    // Counter wrap from 0xFFFF.
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    exp_frames = 16'hFFFF;
    tick();
    check("wrap_preset", bus.frame_cnt, 16'hFFFF);
    start_frame(128'hABCD);
    finish_frame(256'hABCD_EF01, 2, 2, 1'b0);
    check("wrap_zero", bus.frame_cnt, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/encode_sched.md
ENCODE_SCHED -- requirements
Module: encode_sched

Interface
REQ-001 Parameter DW, default 128: width of one uncoded FIFO word; coded frame width is 2*DW.
REQ-002 Parameter TMO, default 1024: cycles allowed between encoder launch and encoder result before abort.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 en  in  1  1 = new frames may be started; 0 = finish current frame, then hold in IDLE.
REQ-006 fifo_empty  in  1  uncoded FIFO empty flag.
REQ-007 fifo_rinc  out  1  one-cycle FIFO pop strobe.
REQ-008 fifo_rdata  in  DW  FIFO read data, valid the cycle after fifo_rinc.
REQ-009 enc_ready  in  1  encoder can accept a word.
REQ-010 enc_vld_i  out  1  one-cycle launch strobe to encoder.
REQ-011 enc_din  out  DW  encoder input word; equals fifo_rdata.
REQ-012 enc_vld_o  in  1  encoder result strobe.
REQ-013 enc_dout  in  2*DW  encoder result, valid with enc_vld_o.
REQ-014 tx_flag  out  1  one-cycle start strobe to UART transmitter.
REQ-015 tx_data  out  2*DW  registered coded frame, stable from tx_flag until tx_ok.
REQ-016 tx_ok  in  1  transmitter finished the frame.
REQ-017 busy  out  1  1 whenever state is not IDLE.
REQ-018 frame_cnt  out  16  frames fully transmitted.
REQ-019 err_tmo  out  1  sticky: an encoder timeout occurred.
REQ-020 err_ovr  out  1  sticky: enc_vld_o seen outside WAIT_ENC.

Function
REQ-021 FSM states SHALL be IDLE, POP, LAUNCH, WAIT_ENC, SEND, WAIT_TX; exactly one frame in flight.
REQ-022 IDLE -> POP when en=1, fifo_empty=0 and enc_ready=1 in the same cycle; otherwise stay.
REQ-023 POP: fifo_rinc=1 for exactly this cycle; unconditional -> LAUNCH.
REQ-024 LAUNCH: enc_vld_i=1 for exactly this cycle, enc_din=fifo_rdata; timeout counter cleared; -> WAIT_ENC.
REQ-025 WAIT_ENC: timeout counter increments each cycle; on enc_vld_o=1 capture enc_dout into tx_data register, -> SEND.
REQ-026 WAIT_ENC: if counter reaches TMO-1 with enc_vld_o=0, set err_tmo, discard frame, -> IDLE; enc_vld_o in that same cycle wins (capture, -> SEND, no error).
REQ-027 SEND: tx_flag=1 for exactly this cycle; -> WAIT_TX.
REQ-028 WAIT_TX: on tx_ok=1 increment frame_cnt (wraps 0xFFFF -> 0x0000), -> IDLE; no timeout.
REQ-029 tx_ok outside WAIT_TX SHALL be ignored.
REQ-030 enc_vld_o in any state other than WAIT_ENC SHALL set err_ovr and SHALL NOT alter tx_data or state.
REQ-031 en deasserted mid-frame SHALL NOT abort; the frame completes, then IDLE holds.
REQ-032 Minimum latency IDLE-qualify edge to tx_flag: POP at n+1, LAUNCH n+2, SEND one cycle after enc_vld_o.
REQ-033 fifo_rinc SHALL never assert while fifo_empty was 1 in the qualifying IDLE cycle.
REQ-034 Back-to-back: IDLE re-qualifies in the cycle after tx_ok-driven return; no bubble beyond IDLE.
REQ-035 Sticky errors clear only on reset.

Reset
REQ-036 rst_n=0 SHALL immediately force state IDLE and fifo_rinc, enc_vld_i, tx_flag, busy, err_tmo, err_ovr to 0, frame_cnt to 0, tx_data to 0, timeout counter to 0.
REQ-037 Reset mid-frame SHALL drop the in-flight frame with no strobe emitted after release until a new IDLE qualification.

Verification
REQ-038 Single frame: push 128'h0123..CDEF, encoder returns result 5 cycles after launch, tx_ok 20 cycles after tx_flag -> exactly one fifo_rinc, one enc_vld_i, one tx_flag, tx_data equals encoder result, frame_cnt=1, busy low after.
REQ-039 Back-to-back: 3 words queued, en=1 -> three complete sequences in order, no overlap of tx_flag with WAIT_TX, frame_cnt=3.
REQ-040 Timeout: TMO=16, encoder silent -> err_tmo=1 at cycle 16 after launch, state IDLE, frame_cnt unchanged; next frame proceeds normally.
REQ-041 Overrun: spurious enc_vld_o during WAIT_TX -> err_ovr=1, tx_data unchanged, frame completes, frame_cnt+1.
REQ-042 Flow control: fifo_empty=1 or enc_ready=0 or en=0 for 50 cycles -> no fifo_rinc, busy=0; en dropped in WAIT_ENC -> frame still transmitted.
REQ-043 Reset mid-WAIT_TX and frame_cnt preset path at 0xFFFF (drive 65536 frames or force) -> reset clears all outputs; wrap gives frame_cnt=0.
